// File: rtl/l2_arbiter.sv
// Purpose: arbitrates I-cache and D-cache line misses onto the single L2 port; build option L2_ARB_ROUND_ROBIN_EN.
// Latency: 1 cycle from request (in IDLE) to L2 request; 0 cycles from l2_resp to the granted side's resp.
// Backpressure: requests are held by the L1 until resp; a grant is held until l2_resp, then one IDLE cycle.
module l2_arbiter #(
  parameter int LINE_W = 128,
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  // I-cache side
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_address,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  // D-cache side
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_address,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  // L2 side
  output logic              l2_read,
  output logic              l2_write,
  output logic [ADDR_W-1:0] l2_address,
  output logic [LINE_W-1:0] l2_wdata,
  input  logic [LINE_W-1:0] l2_rdata,
  input  logic              l2_resp
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_I = 2'd1,
    GRANT_D = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic w_i_req;
  logic w_d_req;
  logic w_d_wins;   // D side wins when both sides request in IDLE

  assign w_i_req = i_read;
  assign w_d_req = d_read | d_write;

`ifdef L2_ARB_ROUND_ROBIN_EN
  // 1 = D side has priority on the next contention, 0 = I side.
  logic r_prio_d;

  assign w_d_wins = r_prio_d;

  // Move the priority pointer to the losing side on every grant out of IDLE.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_prio_d <= 1'b1;
    end else if (r_state == IDLE && w_state_nxt == GRANT_D) begin
      r_prio_d <= 1'b0;
    end else if (r_state == IDLE && w_state_nxt == GRANT_I) begin
      r_prio_d <= 1'b1;
    end
  end
`else
  // Fixed priority: writebacks and data misses always go first.
  assign w_d_wins = 1'b1;
`endif

  // Read data is broadcast; it only matters alongside that side's resp.
  assign i_rdata  = l2_rdata;
  assign d_rdata  = l2_rdata;
  // Only the D side ever writes, so the write line always comes from it.
  assign l2_wdata = d_wdata;

  // State register with synchronous reset; reset mid-transaction drops the grant.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state selection and per-state L2 request / L1 response steering.
  always_comb begin
    w_state_nxt = r_state;
    l2_read     = 1'b0;
    l2_write    = 1'b0;
    l2_address  = d_address;
    i_resp      = 1'b0;
    d_resp      = 1'b0;

    case (r_state)
      IDLE: begin
        // A stray l2_resp here is deliberately ignored.
        if (w_i_req && w_d_req) begin
          w_state_nxt = w_d_wins ? GRANT_D : GRANT_I;
        end else if (w_d_req) begin
          w_state_nxt = GRANT_D;
        end else if (w_i_req) begin
          w_state_nxt = GRANT_I;
        end
      end

      GRANT_I: begin
        l2_read    = 1'b1;
        l2_address = i_address;
        i_resp     = l2_resp;
        if (l2_resp) begin
          w_state_nxt = IDLE;
        end
      end

      GRANT_D: begin
        // An illegal read+write pair is passed through untouched.
        l2_read  = d_read;
        l2_write = d_write;
        d_resp   = l2_resp;
        if (l2_resp) begin
          w_state_nxt = IDLE;
        end
      end

      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_l2_arbiter.sv
// Purpose: directed self-checking bench for l2_arbiter (fixed or round-robin build).
// Latency: inputs driven 2 time units after the rising edge, outputs sampled 1 unit later.
// Backpressure: the bench plays both L1s and the L2, holding requests until resp.
module tb_l2_arbiter;

  localparam int LINE_W = 128;
  localparam int ADDR_W = 16;

  logic              clk;
  logic              reset_n;
  logic              i_read;
  logic [ADDR_W-1:0] i_address;
  logic [LINE_W-1:0] i_rdata;
  logic              i_resp;
  logic              d_read;
  logic              d_write;
  logic [ADDR_W-1:0] d_address;
  logic [LINE_W-1:0] d_wdata;
  logic [LINE_W-1:0] d_rdata;
  logic              d_resp;
  logic              l2_read;
  logic              l2_write;
  logic [ADDR_W-1:0] l2_address;
  logic [LINE_W-1:0] l2_wdata;
  logic [LINE_W-1:0] l2_rdata;
  logic              l2_resp;

  int n_checks = 0;
  int n_pass   = 0;

  l2_arbiter #(.LINE_W(LINE_W), .ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .i_read     (i_read),
    .i_address  (i_address),
    .i_rdata    (i_rdata),
    .i_resp     (i_resp),
    .d_read     (d_read),
    .d_write    (d_write),
    .d_address  (d_address),
    .d_wdata    (d_wdata),
    .d_rdata    (d_rdata),
    .d_resp     (d_resp),
    .l2_read    (l2_read),
    .l2_write   (l2_write),
    .l2_address (l2_address),
    .l2_wdata   (l2_wdata),
    .l2_rdata   (l2_rdata),
    .l2_resp    (l2_resp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [LINE_W-1:0] obs, input logic [LINE_W-1:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance to the next cycle's drive window.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_inputs();
    i_read    = 1'b0;
    i_address = '0;
    d_read    = 1'b0;
    d_write   = 1'b0;
    d_address = '0;
    d_wdata   = '0;
    l2_rdata  = '0;
    l2_resp   = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset_n = 1'b0;
    step();
    step();
    reset_n = 1'b1;
    step();
  endtask

  logic [LINE_W-1:0] pat_a5;
  logic [LINE_W-1:0] rd_line;
  logic              exp_d;

  initial begin
    pat_a5  = {16{8'hA5}};
    rd_line = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    clear_inputs();
    reset_n = 1'b0;
    step();

    // Reset state: requests and a response present during reset are ignored.
    i_read  = 1'b1;
    l2_resp = 1'b1;
    #1;
    check("rst_l2_read", l2_read, 0);
    check("rst_l2_write", l2_write, 0);
    check("rst_i_resp", i_resp, 0);
    check("rst_d_resp", d_resp, 0);
    step();
    #1;
    check("rst_hold_l2_read", l2_read, 0);
    clear_inputs();
    reset_n = 1'b1;
    step();

    // I only, L2 responds 4 cycles after the request appears.
    i_read    = 1'b1;
    i_address = 16'h1230;
    #1;
    check("i_arb_cycle_l2_read", l2_read, 0);
    step();
    #1;
    check("i_l2_read", l2_read, 1);
    check("i_l2_write", l2_write, 0);
    check("i_l2_address", l2_address, 16'h1230);
    for (int k = 0; k < 3; k++) begin
      check("i_wait_resp", i_resp, 0);
      step();
      #1;
    end
    l2_resp  = 1'b1;
    l2_rdata = rd_line;
    #1;
    check("i_resp", i_resp, 1);
    check("i_rdata", i_rdata, rd_line);
    check("i_no_d_resp", d_resp, 0);
    step();
    l2_resp = 1'b0;
    i_read  = 1'b0;
    #1;
    check("i_resp_one_cycle", i_resp, 0);
    check("i_idle_l2_read", l2_read, 0);
    step();

    // D writeback, held through the idle cycle to show the earliest regrant.
    d_write   = 1'b1;
    d_address = 16'h8000;
    d_wdata   = pat_a5;
    step();
    #1;
    check("dw_l2_write", l2_write, 1);
    check("dw_l2_read", l2_read, 0);
    check("dw_l2_address", l2_address, 16'h8000);
    check("dw_l2_wdata", l2_wdata, pat_a5);
    l2_resp = 1'b1;
    #1;
    check("dw_d_resp", d_resp, 1);
    check("dw_no_i_resp", i_resp, 0);
    step();
    l2_resp = 1'b0;
    #1;
    check("dw_idle_l2_write", l2_write, 0);
    check("dw_resp_one_cycle", d_resp, 0);
    step();
    #1;
    check("dw_regrant_m2", l2_write, 1);
    l2_resp = 1'b1;
    #1;
    check("dw2_d_resp", d_resp, 1);
    step();
    clear_inputs();
    step();

    // Simultaneous reads from a fresh reset: D first, I after one idle cycle.
    do_reset();
    i_read    = 1'b1;
    i_address = 16'h1000;
    d_read    = 1'b1;
    d_address = 16'h4000;
    step();
    #1;
    check("sim_first_addr_d", l2_address, 16'h4000);
    check("sim_first_l2_read", l2_read, 1);
    l2_resp = 1'b1;
    #1;
    check("sim_first_d_resp", d_resp, 1);
    check("sim_first_no_i_resp", i_resp, 0);
    step();
    l2_resp = 1'b0;
    d_read  = 1'b0;
    #1;
    check("sim_idle_l2_read", l2_read, 0);
    step();
    #1;
    check("sim_second_addr_i", l2_address, 16'h1000);
    l2_resp = 1'b1;
    #1;
    check("sim_second_i_resp", i_resp, 1);
    check("sim_second_no_d_resp", d_resp, 0);
    step();
    clear_inputs();
    step();
    // Next contention goes to D under both builds.
    i_read    = 1'b1;
    i_address = 16'h1000;
    d_read    = 1'b1;
    d_address = 16'h4000;
    step();
    #1;
    check("sim_next_addr_d", l2_address, 16'h4000);
    l2_resp = 1'b1;
    step();
    clear_inputs();
    step();

    // Continuous contention for 6 transactions.
    do_reset();
    i_read    = 1'b1;
    i_address = 16'h1111;
    d_read    = 1'b1;
    d_address = 16'h2222;
    step();
    for (int t = 0; t < 6; t++) begin
`ifdef L2_ARB_ROUND_ROBIN_EN
      exp_d = (t % 2 == 0);
`else
      exp_d = 1'b1;
`endif
      #1;
      check("starve_addr", l2_address, exp_d ? 16'h2222 : 16'h1111);
      l2_resp = 1'b1;
      #1;
      check("starve_d_resp", d_resp, exp_d);
      check("starve_i_resp", i_resp, !exp_d);
      step();
      l2_resp = 1'b0;
      #1;
      check("starve_idle", l2_read, 0);
      step();
    end
    clear_inputs();
    step();

    // Illegal read+write pair is forwarded unchanged.
    d_read    = 1'b1;
    d_write   = 1'b1;
    d_address = 16'h0AB0;
    step();
    #1;
    check("rw_l2_read", l2_read, 1);
    check("rw_l2_write", l2_write, 1);
    l2_resp = 1'b1;
    step();
    clear_inputs();
    step();

    // Reset while D is granted and waiting.
    d_read    = 1'b1;
    d_address = 16'h2220;
    step();
    #1;
    check("mid_rst_granted", l2_read, 1);
    reset_n = 1'b0;
    #1;
    check("mid_rst_no_d_resp", d_resp, 0);
    step();
    #1;
    check("mid_rst_idle_read", l2_read, 0);
    check("mid_rst_idle_write", l2_write, 0);
    check("mid_rst_idle_resp", d_resp, 0);
    reset_n = 1'b1;
    step();
    #1;
    check("mid_rst_resume", l2_read, 1);
    l2_resp = 1'b1;
    #1;
    check("mid_rst_resume_resp", d_resp, 1);
    step();
    clear_inputs();
    step();

    // Stray response in IDLE.
    l2_resp = 1'b1;
    #1;
    check("stray_i_resp", i_resp, 0);
    check("stray_d_resp", d_resp, 0);
    step();
    l2_resp = 1'b0;
    #1;
    check("stray_stay_idle_read", l2_read, 0);
    check("stray_stay_idle_write", l2_write, 0);
    step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/l2_arbiter.md
# l2_arbiter

Arbitrates line-sized misses from the split L1 instruction and data caches onto the single L1-facing port of the unified L2 cache. Sits directly upstream of the L2 control/datapath: it drives the L2's `mem_read`/`mem_write` request pair and routes the L2's `mem_resp` and read line back to the granted L1. Grants are held for a full transaction, and the arbiter re-arbitrates only from an idle cycle.

## Interface
- `LINE_W`, default 128: cache line width in bits.
- `ADDR_W`, default 16: byte address width.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset_n` in 1: synchronous, active-low reset. Sampled on the rising edge of `clk`.
- `i_read` in 1: I-cache line read request, held until `i_resp`.
- `i_address` in ADDR_W: I-cache line address.
- `i_rdata` out LINE_W: read line to the I-cache.
- `i_resp` out 1: one-cycle completion pulse to the I-cache.
- `d_read` in 1: D-cache line read request, held until `d_resp`.
- `d_write` in 1: D-cache line write (writeback) request, held until `d_resp`.
- `d_address` in ADDR_W: D-cache line address.
- `d_wdata` in LINE_W: D-cache write line.
- `d_rdata` out LINE_W: read line to the D-cache.
- `d_resp` out 1: one-cycle completion pulse to the D-cache.
- `l2_read` out 1: read request to the L2.
- `l2_write` out 1: write request to the L2.
- `l2_address` out ADDR_W: request address to the L2.
- `l2_wdata` out LINE_W: write line to the L2.
- `l2_rdata` in LINE_W: read line from the L2.
- `l2_resp` in 1: completion from the L2.

## Operation
- State machine states:
  - `IDLE`: no grant; all L2 request outputs are 0.
  - `GRANT_I`: I-cache owns the L2 port.
  - `GRANT_D`: D-cache owns the L2 port.
- Transitions out of `IDLE`:
  - Only `i_read` asserted: go to `GRANT_I`.
  - Only `d_read` or `d_write` asserted: go to `GRANT_D`.
  - Both sides requesting: the winner is set by the priority rule (see Configuration).
  - No request: stay in `IDLE`.
- Transitions out of `GRANT_I` / `GRANT_D`:
  - Stay in the grant state until `l2_resp` is asserted.
  - On `l2_resp`, go to `IDLE` unconditionally.
  - The mandatory idle cycle lets the L1 drop its request before any re-arbitration.
- `GRANT_I` outputs:
  - `l2_read`=1, `l2_write`=0, `l2_address`=`i_address`.
  - `i_resp`=`l2_resp` (combinational).
- `GRANT_D` outputs:
  - `l2_read`=`d_read`, `l2_write`=`d_write`, `l2_address`=`d_address`, `l2_wdata`=`d_wdata`.
  - `d_resp`=`l2_resp`.
- `i_rdata` and `d_rdata` are both driven from `l2_rdata` at all times. The data is only meaningful alongside that side's `resp`.
- In `IDLE`, `l2_address`/`l2_wdata` are driven from the D side. Their values are don't-care while read and write are both 0.
- `d_read` and `d_write` asserted together is illegal; the arbiter forwards both unchanged.
- A request withdrawn before `resp` is a protocol violation. The grant is held until `l2_resp` regardless.
- `l2_resp` arriving in `IDLE` is ignored: no `resp` is pulsed to either side.

## Timing
- Reset values: state=`IDLE`, `l2_read`=0, `l2_write`=0, `i_resp`=0, `d_resp`=0; priority pointer (when built in) = D side.
- Reset asserted mid-transaction: return to `IDLE` at that edge, and the L2 request drops on the next cycle.
- Request latency:
  - A request first visible in cycle N while in `IDLE` produces an L2 request in cycle N+1.
  - Exactly 1 cycle of arbitration overhead.
- Response latency:
  - Zero cycles: `l2_resp` in cycle M gives the granted `*_resp` in cycle M.
  - State is `IDLE` in M+1.
  - The earliest next grant is visible in M+2.
- Back-to-back requests from the same side are separated by at least one `IDLE` cycle.
- `*_resp` is never asserted for more than one cycle per transaction.

## Configuration
- `L2_ARB_ROUND_ROBIN_EN` defined:
  - A 1-bit priority pointer decides simultaneous requests in `IDLE`.
  - The pointer moves to the loser at each grant, so contending sides alternate.
  - The pointer resets to D.
- `L2_ARB_ROUND_ROBIN_EN` undefined:
  - Fixed priority: the D side always wins simultaneous requests.
  - No pointer register exists.

## Test plan
- I only: `i_read`=1 at `i_address`=0x1230, L2 responds 4 cycles after request -> `l2_read`=1 at `l2_address`=0x1230 from the next cycle; `i_resp`=1 for exactly one cycle with `i_rdata`=`l2_rdata`; `d_resp` stays 0.
- D writeback: `d_write`=1 at `d_address`=0x8000, `d_wdata`=0xA5 repeated -> `l2_write`=1, `l2_wdata` matches; single `d_resp` pulse; state returns to `IDLE` the cycle after.
- Simultaneous: `i_read` and `d_read` asserted together, both held:
  - Without the macro: D served first, then I after one `IDLE` cycle.
  - With the macro: D first, I second, and the next contention goes to D again.
- Starvation (`L2_ARB_ROUND_ROBIN_EN` defined): both sides re-request continuously for 6 transactions -> grants alternate D, I, D, I, D, I.
- Reset mid-operation: `reset_n`=0 while in `GRANT_D` before `l2_resp` -> `IDLE` next cycle, `l2_read`/`l2_write`=0, no `d_resp`; normal service resumes after release.
- Stray response: `l2_resp`=1 while in `IDLE` -> `i_resp`=`d_resp`=0, state unchanged.
